// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter with a one-entry register file write stage
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic [ADDR_W-1:0] rd_addr0_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  output logic              hazard0_o,
  output logic              hazard1_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] wr_addr0_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [31:0]       commit_cnt_o
);

  // Which requester won the most recent grant; the other one wins the next conflict.
  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } last_grant_t;

  last_grant_t       last_q;
  last_grant_t       last_d;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [31:0]       commit_cnt_q;

  // Grant selection: lone requester wins, a conflict goes to whoever was not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    last_d = last_q;
    if (!rst) begin
      if (req0_valid_i && (!req1_valid_i || last_q == LAST_REQ1)) begin
        grant0 = 1'b1;
      end else if (req1_valid_i) begin
        grant1 = 1'b1;
      end
    end
    if (grant0) begin
      last_d = LAST_REQ0;
    end else if (grant1) begin
      last_d = LAST_REQ1;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign sel_addr     = grant1 ? req1_addr_i : req0_addr_i;
  assign sel_data     = grant1 ? req1_data_i : req0_data_i;

  // Last-grant pointer; reset points at req1 so req0 takes the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= LAST_REQ1;
    end else begin
      last_q <= last_d;
    end
  end

  // Output stage: capture the accepted request; r0 writes are captured but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (grant0 || grant1) begin
      we_q      <= (sel_addr != '0);
      wr_addr_q <= sel_addr;
      wr_data_q <= sel_data;
    end else begin
      we_q      <= 1'b0;
    end
  end

  // Commit counter: one per cycle spent with the write enable high, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_cnt_q <= 32'd0;
    end else if (we_q) begin
      commit_cnt_q <= commit_cnt_q + 32'd1;
    end
  end

  assign we_o         = we_q;
  assign wr_addr0_o   = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign commit_cnt_o = commit_cnt_q;

  // A read of a register whose write is sitting in the stage must wait; r0 never conflicts.
  assign hazard0_o = we_q && (rd_addr0_i == wr_addr_q) && (rd_addr0_i != '0);
  assign hazard1_o = we_q && (rd_addr1_i == wr_addr_q) && (rd_addr1_i != '0);

endmodule
